coloring_checker: RTL

//  Post-run verifier for the 4-colour CPU. Sits downstream of memory and consumes the solver's result in place.

---
 rtl/coloring_checker_if.sv | 28 ++
 rtl/coloring_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/coloring_checker_if.sv
// Bus and result signals between the colouring checker and its surroundings.
// master: the checker itself; slave: the memory mux / host side.
interface coloring_checker_if;
    logic       start;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic       bus_req;
    logic       busy;
    logic       done;
    logic       pass;
    logic       err_valid;
    logic [1:0] err_code;
    logic [7:0] err_node;
    logic [7:0] err_nbr;
    logic [7:0] err_count;

    modport master (
        input  start, mem_rdata,
        output mem_addr, bus_req, busy, done, pass,
               err_valid, err_code, err_node, err_nbr, err_count
    );

    modport slave (
        output start, mem_rdata,
        input  mem_addr, bus_req, busy, done, pass,
               err_valid, err_code, err_node, err_nbr, err_count
    );
endinterface

// File: rtl/coloring_checker.sv
// Post-run verifier for a 4-colour solver result held in memory.
// Walks the CSR graph (offset table + adjacency list) and the colour table,
// one memory read per cycle, and reports the first error plus an error count.
module coloring_checker #(
    parameter int N_NODES    = 32,
    parameter int ADJ_BASE   = 0,
    parameter int OFF_BASE   = 148,
    parameter int COLOR_BASE = 181,
    parameter int NUM_COLORS = 4
) (
    input  logic                clk,
    input  logic                rst,
    coloring_checker_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_OFS,
        S_RD_OFE,
        S_RD_CV,
        S_RD_NBR,
        S_RD_CN,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_EDGE  = 2'b01;
    localparam logic [1:0] ERR_COLOR = 2'b10;
    localparam logic [1:0] ERR_NBR   = 2'b11;

    localparam logic [7:0] ADJ_B   = 8'(ADJ_BASE);
    localparam logic [7:0] OFF_B   = 8'(OFF_BASE);
    localparam logic [7:0] COL_B   = 8'(COLOR_BASE);
    localparam logic [7:0] N_LAST  = 8'(N_NODES - 1);
    localparam logic [7:0] N_LIM   = 8'(N_NODES);
    localparam logic [7:0] COL_MAX = 8'(NUM_COLORS);

    state_t     state_q, state_d;
    logic [7:0] v_q, v_d;
    logic [7:0] e_q, e_d;
    logic [7:0] e_end_q, e_end_d;
    logic [7:0] cv_q, cv_d;
    logic [7:0] nbr_q, nbr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       err_valid_q, err_valid_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] err_node_q, err_node_d;
    logic [7:0] err_nbr_q, err_nbr_d;
    logic [7:0] err_count_q, err_count_d;

    // per-cycle error report and end-of-node request
    logic       log_err;
    logic [1:0] log_code;
    logic [7:0] log_nbr;
    logic       go_next;

    // Read address is a pure function of the state registers: one read per cycle.
    always_comb begin
        bus.mem_addr = 8'd0;
        case (state_q)
            S_RD_OFS: bus.mem_addr = OFF_B + v_q;
            S_RD_OFE: bus.mem_addr = OFF_B + v_q + 8'd1;
            S_RD_CV:  bus.mem_addr = COL_B + v_q;
            S_RD_NBR: bus.mem_addr = ADJ_B + e_q;
            S_RD_CN:  bus.mem_addr = COL_B + nbr_q;   // wraps mod 256 for bad ids
            default:  bus.mem_addr = 8'd0;
        endcase
    end

    // Next-state, walk counters and error bookkeeping.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        e_d         = e_q;
        e_end_d     = e_end_q;
        cv_d        = cv_q;
        nbr_d       = nbr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_node_d  = err_node_q;
        err_nbr_d   = err_nbr_q;
        err_count_d = err_count_q;
        log_err     = 1'b0;
        log_code    = 2'b00;
        log_nbr     = 8'd0;
        go_next     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_RD_OFS;
                    v_d         = 8'd0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_valid_d = 1'b0;
                    err_code_d  = 2'b00;
                    err_node_d  = 8'd0;
                    err_nbr_d   = 8'd0;
                    err_count_d = 8'd0;
                end
            end
            S_RD_OFS: begin
                e_d     = bus.mem_rdata;
                state_d = S_RD_OFE;
            end
            S_RD_OFE: begin
                e_end_d = bus.mem_rdata;
                state_d = S_RD_CV;
            end
            S_RD_CV: begin
                cv_d = bus.mem_rdata;
                if (bus.mem_rdata == 8'd0 || bus.mem_rdata > COL_MAX) begin
                    log_err  = 1'b1;
                    log_code = ERR_COLOR;
                    log_nbr  = 8'd0;
                end
                // e_end < e (corrupt table) falls through as zero-degree
                if (e_q < e_end_q) state_d = S_RD_NBR;
                else               go_next = 1'b1;
            end
            S_RD_NBR: begin
                nbr_d   = bus.mem_rdata;
                state_d = S_RD_CN;
            end
            S_RD_CN: begin
                if (nbr_q >= N_LIM) begin
                    log_err  = 1'b1;
                    log_code = ERR_NBR;
                    log_nbr  = nbr_q;
                end else if (bus.mem_rdata == cv_q) begin
                    log_err  = 1'b1;
                    log_code = ERR_EDGE;
                    log_nbr  = nbr_q;
                end
                e_d = e_q + 8'd1;
                if (({1'b0, e_q} + 9'd1) < {1'b0, e_end_q}) state_d = S_RD_NBR;
                else                                          go_next = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // First error wins the err_* fields; every error bumps the count.
        if (log_err) begin
            if (!err_valid_q) begin
                err_code_d = log_code;
                err_node_d = v_q;
                err_nbr_d  = log_nbr;
            end
            err_valid_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end

        // Node finished: advance without spending a cycle, or wrap up.
        if (go_next) begin
            if (v_q == N_LAST) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = ~err_valid_d;
            end else begin
                v_d     = v_q + 8'd1;
                state_d = S_RD_OFS;
            end
        end
    end

    // State and registered outputs; reset aborts any check immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            v_q         <= 8'd0;
            e_q         <= 8'd0;
            e_end_q     <= 8'd0;
            cv_q        <= 8'd0;
            nbr_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_node_q  <= 8'd0;
            err_nbr_q   <= 8'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            e_q         <= e_d;
            e_end_q     <= e_end_d;
            cv_q        <= cv_d;
            nbr_q       <= nbr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_node_q  <= err_node_d;
            err_nbr_q   <= err_nbr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.bus_req   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;
    assign bus.err_node  = err_node_q;
    assign bus.err_nbr   = err_nbr_q;
    assign bus.err_count = err_count_q;

endmodule
